btn_ctrl: RTL and testbench

- Input-side companion to the io display path: io drives seg from board state; btn_ctrl turns raw board buttons into move commands for the CPU.
- Synchronizes and debounces btn[4:0], detects presses, encodes each press as a 5-bit move code, buffers codes in a small FIFO.
- CPU side pops codes with a read strobe; the 5-bit code width matches the datapath data width.

---
 rtl/btn_ctrl_if.sv | 23 ++
 rtl/btn_ctrl.sv | 116 +++++++++++
 tb/tb_btn_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/btn_ctrl_if.sv
// Board-button command bus between btn_ctrl and its CPU-side consumer.
// Raw buttons and pop/clear strobes go in; move codes and status come out.
interface btn_ctrl_if #(
    parameter int CW = 3
);
    logic [4:0]    btn;
    logic          rd;
    logic          clr_ovf;
    logic [4:0]    key;
    logic          key_valid;
    logic [CW-1:0] count;
    logic          ovf;

    modport master (
        output btn, rd, clr_ovf,
        input  key, key_valid, count, ovf
    );

    modport slave (
        input  btn, rd, clr_ovf,
        output key, key_valid, count, ovf
    );
endinterface

// File: rtl/btn_ctrl.sv
// Button synchronizer, debouncer and press-to-move-code encoder.
// Each press queues a 5-bit move code in a small FIFO for the CPU.
module btn_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DEPTH      = 4,
    parameter int CW         = 3
) (
    input logic       clk,
    input logic       rst,
    btn_ctrl_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int DW = $clog2(DEB_CYCLES);

    logic [4:0]    s1;
    logic [4:0]    s2;
    logic [4:0]    deb;
    logic [4:0]    deb_d;
    logic [4:0]    press;
    logic [DW-1:0] cnt [5];

    logic [4:0]    code;
    logic          push;
    logic          do_push;
    logic          do_pop;
    logic          full;
    logic          empty;

    logic [4:0]    mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic [CW-1:0] count_r;
    logic          ovf_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1    <= bus.btn;
            s2    <= s1;
            deb_d <= deb;
            press <= deb & ~deb_d;
            for (int i = 0; i < 5; i++) begin
                if (s2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DW'(DEB_CYCLES - 1)) begin
                    deb[i] <= ~deb[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Lowest-index button wins when several rise together.
    always_comb begin
        code = '0;
        for (int i = 4; i >= 0; i--) begin
            if (press[i]) begin
                code = 5'(i + 1);
            end
        end
    end

    assign push    = |press;
    assign full    = (count_r == CW'(DEPTH));
    assign empty   = (count_r == '0);
    assign do_pop  = bus.rd && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            count_r <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
            // A fresh overflow beats a same-cycle clear.
            if (push && full && !do_pop) begin
                ovf_r <= 1'b1;
            end else if (bus.clr_ovf) begin
                ovf_r <= 1'b0;
            end
        end
    end

    assign bus.key       = empty ? 5'd0 : mem[rp];
    assign bus.key_valid = !empty;
    assign bus.count     = count_r;
    assign bus.ovf       = ovf_r;
endmodule

// File: tb/tb_btn_ctrl.sv
// Directed testbench for btn_ctrl: debounce timing, FIFO order,
// overflow, simultaneous presses and reset during a held button.
module tb_btn_ctrl;
    logic clk;
    logic rst;
    int   vectors;
    int   errs;

    btn_ctrl_if #(.CW(3)) bif ();

    btn_ctrl #(
        .DEB_CYCLES(4),
        .DEPTH(4),
        .CW(3)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .bus(bif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [4:0] b);
        bif.btn = b;
        step(12);
        bif.btn = 5'd0;
        step(12);
    endtask

    task automatic pop;
        bif.rd = 1'b1;
        step(1);
        bif.rd = 1'b0;
    endtask

    task automatic status(input string tag, input logic [4:0] k,
                          input logic v, input logic [2:0] c,
                          input logic o);
        chk({tag, "_key"}, {3'd0, bif.key}, {3'd0, k});
        chk({tag, "_valid"}, {7'd0, bif.key_valid}, {7'd0, v});
        chk({tag, "_count"}, {5'd0, bif.count}, {5'd0, c});
        chk({tag, "_ovf"}, {7'd0, bif.ovf}, {7'd0, o});
    endtask

    initial begin
        vectors     = 0;
        errs        = 0;
        rst         = 1'b1;
        bif.btn     = 5'd0;
        bif.rd      = 1'b0;
        bif.clr_ovf = 1'b0;
        step(3);
        rst = 1'b0;
        status("reset", 5'd0, 1'b0, 3'd0, 1'b0);

        // Latency of a single held press
        bif.btn = 5'b00001;
        step(7);
        status("lat_e6", 5'd0, 1'b0, 3'd0, 1'b0);
        step(1);
        status("lat_e7", 5'd1, 1'b1, 3'd1, 1'b0);
        step(20);
        status("held", 5'd1, 1'b1, 3'd1, 1'b0);
        bif.btn = 5'd0;
        step(12);
        pop();
        status("pop1", 5'd0, 1'b0, 3'd0, 1'b0);
        pop();
        status("rd_empty", 5'd0, 1'b0, 3'd0, 1'b0);

        // 3-cycle glitch is rejected
        bif.btn = 5'b00100;
        step(3);
        bif.btn = 5'd0;
        step(12);
        status("glitch", 5'd0, 1'b0, 3'd0, 1'b0);

        // FIFO ordering
        press(5'b01000);
        press(5'b00100);
        press(5'b00010);
        press(5'b00001);
        status("fill", 5'd4, 1'b1, 3'd4, 1'b0);
        pop();
        status("fifo_a", 5'd3, 1'b1, 3'd3, 1'b0);
        pop();
        status("fifo_b", 5'd2, 1'b1, 3'd2, 1'b0);
        pop();
        status("fifo_c", 5'd1, 1'b1, 3'd1, 1'b0);
        pop();
        status("fifo_d", 5'd0, 1'b0, 3'd0, 1'b0);

        // Overflow and clear
        press(5'b00001);
        press(5'b00010);
        press(5'b00100);
        press(5'b01000);
        press(5'b10000);
        status("ovf", 5'd1, 1'b1, 3'd4, 1'b1);
        bif.clr_ovf = 1'b1;
        step(1);
        bif.clr_ovf = 1'b0;
        status("clr", 5'd1, 1'b1, 3'd4, 1'b0);

        // Overflow beats a same-cycle clear
        bif.btn = 5'b10000;
        step(7);
        bif.clr_ovf = 1'b1;
        step(1);
        bif.clr_ovf = 1'b0;
        status("ovf_win", 5'd1, 1'b1, 3'd4, 1'b1);
        bif.btn = 5'd0;
        step(12);
        bif.clr_ovf = 1'b1;
        step(1);
        bif.clr_ovf = 1'b0;
        chk("clr2", {7'd0, bif.ovf}, 8'd0);

        // Push and pop together while full
        bif.btn = 5'b00001;
        step(7);
        bif.rd = 1'b1;
        step(1);
        bif.rd = 1'b0;
        status("pp_full", 5'd2, 1'b1, 3'd4, 1'b0);
        bif.btn = 5'd0;
        step(12);
        pop();
        status("pp_a", 5'd3, 1'b1, 3'd3, 1'b0);
        pop();
        status("pp_b", 5'd4, 1'b1, 3'd2, 1'b0);
        pop();
        status("pp_c", 5'd1, 1'b1, 3'd1, 1'b0);
        pop();
        status("pp_d", 5'd0, 1'b0, 3'd0, 1'b0);

        // Simultaneous right+center
        press(5'b11000);
        status("simul", 5'd4, 1'b1, 3'd1, 1'b0);
        pop();
        status("simul_pop", 5'd0, 1'b0, 3'd0, 1'b0);

        // Held button across resets
        bif.btn = 5'b00010;
        step(3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        step(7);
        status("rst1_e6", 5'd0, 1'b0, 3'd0, 1'b0);
        step(1);
        status("rst1_e7", 5'd2, 1'b1, 3'd1, 1'b0);
        step(5);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        status("rst2", 5'd0, 1'b0, 3'd0, 1'b0);
        step(7);
        status("rst2_e6", 5'd0, 1'b0, 3'd0, 1'b0);
        step(1);
        status("rst2_e7", 5'd2, 1'b1, 3'd1, 1'b0);
        step(20);
        status("rst2_held", 5'd2, 1'b1, 3'd1, 1'b0);
        bif.btn = 5'd0;
        step(5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
